// File: rtl/uart_rx_core.sv
// UART receive core: start-bit validation, LSB-first data capture,
// stop-bit check, one-cycle valid / framing-error pulses.
module uart_rx_core #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       rx_i,
    input  logic       fall_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shreg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            data_o      <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fall_i) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                // A high line at mid-start-bit means the edge was noise.
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= rx_i ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {rx_i, shreg[7:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
                            state <= STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // Leave at mid-stop-bit so a back-to-back start edge is seen.
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_i) begin
                            data_o  <= shreg;
                            valid_o <= 1'b1;
                        end else begin
                            frame_err_o <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o = (state != IDLE);

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk_i cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk_i, input, 1, clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n_i, input, 1, reset: asynchronous, active-low.
REQ-004 SHALL have port rx_i, input, 1, serial line, already synchronized to clk_i, idle high.
REQ-005 SHALL have port fall_i, input, 1, one-cycle falling-edge strobe of rx_i from the upstream edge detector.
REQ-006 SHALL have port data_o, output, 8, last correctly framed byte.
REQ-007 SHALL have port valid_o, output, 1, one-cycle pulse: data_o updated with a good frame.
REQ-008 SHALL have port frame_err_o, output, 1, one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port busy_o, output, 1, high whenever the state is not IDLE.

Function
REQ-010 SHALL implement states IDLE, START, DATA, STOP, with a bit counter (0..CLKS_PER_BIT-1, width clog2(CLKS_PER_BIT)) and a 3-bit data-bit index.
REQ-011 SHALL define H = floor(CLKS_PER_BIT/2) and C = CLKS_PER_BIT; the clock edge where fall_i=1 is seen in IDLE is T0.
REQ-012 IDLE: on fall_i=1, SHALL go to START at T0 with the counter cleared; otherwise stay in IDLE.
REQ-013 SHALL ignore fall_i in START, DATA and STOP.
REQ-014 START: the counter SHALL increment each cycle, and rx_i SHALL be sampled at the edge where the counter equals H-1 (edge T0+H).
REQ-015 START sample 0 SHALL go to DATA with counter and index cleared.
REQ-016 START sample 1 SHALL be treated as a glitch: return to IDLE with no output pulse.
REQ-017 DATA: SHALL sample rx_i when the counter equals C-1 (edges T0+H+k*C, k=1..8), clear the counter, and shift the sample into an 8-bit register LSB first.
REQ-018 After the 8th data sample, SHALL go to STOP.
REQ-019 STOP: SHALL sample rx_i when the counter equals C-1 (edge T0+H+9*C), then go to IDLE on that same edge.
REQ-020 Stop sample 1: at that edge, SHALL load data_o with the shift register and set valid_o=1 for exactly one cycle.
REQ-021 Stop sample 0: at that edge, SHALL set frame_err_o=1 for exactly one cycle and leave data_o unchanged.
REQ-022 valid_o and frame_err_o SHALL never be high in the same cycle, and SHALL be 0 in every other cycle.
REQ-023 data_o SHALL hold its value until the next good frame; there is no consumer back-pressure, and a new frame overwrites data_o.
REQ-024 The return to IDLE at mid-stop-bit SHALL allow a fall_i arriving C-H or more cycles later (the next start bit) to be accepted with no lost frame.
REQ-025 Counter arithmetic SHALL be unsigned and SHALL never wrap: it is cleared at every sample point and on entry to START.

Reset
REQ-026 While rst_n_i=0, SHALL immediately force state=IDLE, counter=0, index=0, shift register=0x00, data_o=0x00, valid_o=0, frame_err_o=0, busy_o=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no output pulse.
REQ-028 After rst_n_i deasserts, the first accepted event SHALL be a fall_i seen in IDLE.

Verification (CLKS_PER_BIT=16, so H=8; frames driven on rx_i with a matching fall_i strobe)
REQ-029 Reset check: hold rst_n_i=0 with random rx_i/fall_i -> all outputs 0, busy_o=0.
REQ-030 Good frame 0xA5, stop=1 -> busy_o high from T0, valid_o=1 only in the cycle after edge T0+152, data_o=0xA5, frame_err_o=0.
REQ-031 Glitch: fall_i, with rx_i low for 3 cycles then high -> IDLE at edge T0+8, no valid_o, no frame_err_o, data_o unchanged.
REQ-032 Framing error: frame 0x3C with stop=0, after the 0xA5 frame -> frame_err_o one-cycle pulse after edge T0+152, valid_o=0, data_o stays 0xA5.
REQ-033 Back-to-back: frames 0x00 then 0xFF, the second start bit immediately following the first stop bit -> two valid_o pulses 160 cycles apart, data_o=0x00 then 0xFF.
REQ-034 Mid-frame reset: assert rst_n_i during data bit 3 of 0x5A -> outputs 0, state IDLE, no pulse; a following frame 0x81 -> valid_o with data_o=0x81.
